alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arb_pkg.sv | 15 +
 rtl/alu_arb_rsp_slot.sv | 45 ++++
 rtl/alu_arbiter.sv | 119 +++++++++++
 tb/tb_alu_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared widths, ALU op encodings and round-robin state for alu_arbiter
package alu_arb_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int CTRL_W_DEF = 3;
    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011
    } alu_op_e;
    typedef enum logic {
        PRI0 = 1'b0,
        PRI1 = 1'b1
    } rr_state_e;
endpackage

// File: rtl/alu_arb_rsp_slot.sv
// alu_arb_rsp_slot: one registered response slot with valid/ready handshake
// Ports: clk, rst_n (async active-low); i_load captures i_result/i_eq and sets valid;
//        i_ready consumes the held response; o_valid/o_result/o_eq hold it;
//        o_free says the slot can take a new result this cycle.
module alu_arb_rsp_slot
    import alu_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_result,
    input  logic              i_eq,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_result,
    output logic              o_eq,
    output logic              o_free
);
    logic              r_valid;
    logic [DATA_W-1:0] r_result;
    logic              r_eq;

    // A load wins over a consume, so a slot drained and refilled in the same
    // cycle stays valid and sustains one result per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_result <= '0;
            r_eq     <= 1'b0;
        end else if (i_load) begin
            r_valid  <= 1'b1;
            r_result <= i_result;
            r_eq     <= i_eq;
        end else if (i_ready) begin
            r_valid  <= 1'b0;
        end
    end

    assign o_valid  = r_valid;
    assign o_result = r_result;
    assign o_eq     = r_eq;
    assign o_free   = !r_valid | i_ready;
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one external ALU between two requesters
// Ports: clk, rst_n (async active-low); reqN_valid/ready/op1/op2/ctrl request side;
//        rspN_valid/ready/result/eq registered response side; alu_op1/op2/ctrl drive
//        the shared ALU, alu_out/alu_eq come back combinationally.
// Optional: define ALU_ARB_STATS_EN to add gnt_cnt0/gnt_cnt1 saturating transfer counters.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_op1,
    input  logic [DATA_W-1:0] req0_op2,
    input  logic [CTRL_W-1:0] req0_ctrl,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_op1,
    input  logic [DATA_W-1:0] req1_op2,
    input  logic [CTRL_W-1:0] req1_ctrl,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_result,
    output logic              rsp0_eq,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_result,
    output logic              rsp1_eq,
    output logic [DATA_W-1:0] alu_op1,
    output logic [DATA_W-1:0] alu_op2,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_eq
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [15:0]       gnt_cnt0,
    output logic [15:0]       gnt_cnt1
`endif
);
    rr_state_e r_state;
    rr_state_e w_state_next;
    logic      w_free0, w_free1;
    logic      w_elig0, w_elig1;
    logic      w_gnt0, w_gnt1;

    // Gating with rst_n keeps any grant from being issued while reset is held.
    assign w_elig0 = rst_n & req0_valid & w_free0;
    assign w_elig1 = rst_n & req1_valid & w_free1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= PRI0;
        else        r_state <= w_state_next;
    end

    // The pointer only matters on contention; after a grant the other side gets priority.
    always_comb begin
        w_gnt0       = w_elig0;
        w_gnt1       = w_elig1;
        w_state_next = r_state;
        if (w_elig0 && w_elig1) begin
            w_gnt0 = (r_state == PRI0);
            w_gnt1 = (r_state == PRI1);
        end
        if (w_gnt0)      w_state_next = PRI1;
        else if (w_gnt1) w_state_next = PRI0;
    end

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;
    assign alu_op1    = w_gnt0 ? req0_op1  : w_gnt1 ? req1_op1  : '0;
    assign alu_op2    = w_gnt0 ? req0_op2  : w_gnt1 ? req1_op2  : '0;
    assign alu_ctrl   = w_gnt0 ? req0_ctrl : w_gnt1 ? req1_ctrl : '0;

    alu_arb_rsp_slot #(.DATA_W(DATA_W)) u_slot0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_gnt0),
        .i_result (alu_out),
        .i_eq     (alu_eq),
        .i_ready  (rsp0_ready),
        .o_valid  (rsp0_valid),
        .o_result (rsp0_result),
        .o_eq     (rsp0_eq),
        .o_free   (w_free0)
    );

    alu_arb_rsp_slot #(.DATA_W(DATA_W)) u_slot1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_gnt1),
        .i_result (alu_out),
        .i_eq     (alu_eq),
        .i_ready  (rsp1_ready),
        .o_valid  (rsp1_valid),
        .o_result (rsp1_result),
        .o_eq     (rsp1_eq),
        .o_free   (w_free1)
    );

`ifdef ALU_ARB_STATS_EN
    logic [15:0] r_cnt0, r_cnt1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_gnt0 && r_cnt0 != 16'hFFFF) r_cnt0 <= r_cnt0 + 16'd1;
            if (w_gnt1 && r_cnt1 != 16'hFFFF) r_cnt1 <= r_cnt1 + 16'd1;
        end
    end

    assign gnt_cnt0 = r_cnt0;
    assign gnt_cnt1 = r_cnt1;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: table-driven and directed checks of alu_arbiter with a behavioural ALU
module tb_alu_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_op1 = '0, req0_op2 = '0, req1_op1 = '0, req1_op2 = '0;
    logic [2:0]  req0_ctrl = '0, req1_ctrl = '0;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
    logic [31:0] rsp0_result, rsp1_result;
    logic        rsp0_eq, rsp1_eq;
    logic [31:0] alu_op1, alu_op2, alu_out;
    logic [2:0]  alu_ctrl;
    logic        alu_eq;
`ifdef ALU_ARB_STATS_EN
    logic [15:0] gnt_cnt0, gnt_cnt1;
`endif
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    assign alu_out = (alu_ctrl == 3'd0) ? alu_op1 + alu_op2 :
                     (alu_ctrl == 3'd1) ? alu_op1 - alu_op2 :
                     (alu_ctrl == 3'd2) ? alu_op1 & alu_op2 :
                     (alu_ctrl == 3'd3) ? alu_op1 | alu_op2 : 32'd0;
    assign alu_eq  = (alu_op1 == alu_op2);

    alu_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_ctrl(req0_ctrl),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_ctrl(req1_ctrl),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_eq(rsp0_eq),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_eq(rsp1_eq),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_ctrl(alu_ctrl), .alu_out(alu_out), .alu_eq(alu_eq)
`ifdef ALU_ARB_STATS_EN
        , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
`endif
    );

    typedef struct {
        logic        v0;
        logic [31:0] a0, b0;
        logic [2:0]  c0;
        logic        v1;
        logic [31:0] a1, b1;
        logic [2:0]  c1;
        logic        e_r0, e_r1;
        logic [31:0] e_res;
        logic        e_eq;
    } vec_t;

    vec_t tv[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic [31:0] a0, input logic [31:0] b0, input logic [2:0] c0,
                         input logic v1, input logic [31:0] a1, input logic [31:0] b1, input logic [2:0] c1);
        req0_valid = v0; req0_op1 = a0; req0_op2 = b0; req0_ctrl = c0;
        req1_valid = v1; req1_op1 = a1; req1_op2 = b1; req1_ctrl = c1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        tv[0] = '{1'b1, 32'd5, 32'd3, 3'd1, 1'b0, 32'd0, 32'd0, 3'd0, 1'b1, 1'b0, 32'd2, 1'b0};
        tv[1] = '{1'b1, 32'd1, 32'd2, 3'd0, 1'b1, 32'd7, 32'd7, 3'd0, 1'b0, 1'b1, 32'd14, 1'b1};
        tv[2] = '{1'b1, 32'hF0F0, 32'hFF00, 3'd2, 1'b1, 32'd1, 32'd2, 3'd3, 1'b1, 1'b0, 32'hF000, 1'b0};
        tv[3] = '{1'b1, 32'hF0F0, 32'hFF00, 3'd2, 1'b1, 32'd1, 32'd2, 3'd3, 1'b0, 1'b1, 32'd3, 1'b0};
        tv[4] = '{1'b0, 32'd0, 32'd0, 3'd0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd7, 1'b0, 1'b1, 32'd0, 1'b1};
        tv[5] = '{1'b0, 32'd0, 32'd0, 3'd0, 1'b1, 32'd10, 32'd3, 3'd1, 1'b0, 1'b1, 32'd7, 1'b0};
        tv[6] = '{1'b0, 32'd9, 32'd9, 3'd0, 1'b0, 32'd8, 32'd8, 3'd0, 1'b0, 1'b0, 32'd0, 1'b0};
        tv[7] = '{1'b1, 32'd3, 32'd5, 3'd1, 1'b0, 32'd0, 32'd0, 3'd0, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0};
        tv[8] = '{1'b1, 32'd1, 32'd1, 3'd0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd4, 1'b0, 1'b1, 32'd0, 1'b1};
        tv[9] = '{1'b1, 32'hA, 32'h5, 3'd3, 1'b1, 32'd2, 32'd2, 3'd0, 1'b1, 1'b0, 32'hF, 1'b0};

        // Reset state, with a request pending so that no grant under reset is visible
        req0_valid = 1'b1;
        #2;
        chk("rst rsp0_valid", 32'(rsp0_valid), 32'd0);
        chk("rst rsp1_valid", 32'(rsp1_valid), 32'd0);
        chk("rst rsp0_result", rsp0_result, 32'd0);
        chk("rst rsp1_eq", 32'(rsp1_eq), 32'd0);
        chk("rst req0_ready", 32'(req0_ready), 32'd0);
        chk("rst alu_op1", alu_op1, 32'd0);
        req0_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            drive(tv[i].v0, tv[i].a0, tv[i].b0, tv[i].c0, tv[i].v1, tv[i].a1, tv[i].b1, tv[i].c1);
            #1;
            chk($sformatf("v%0d req0_ready", i), 32'(req0_ready), 32'(tv[i].e_r0));
            chk($sformatf("v%0d req1_ready", i), 32'(req1_ready), 32'(tv[i].e_r1));
            chk($sformatf("v%0d alu_op1", i), alu_op1, tv[i].e_r0 ? tv[i].a0 : tv[i].e_r1 ? tv[i].a1 : 32'd0);
            chk($sformatf("v%0d alu_ctrl", i), 32'(alu_ctrl), 32'(tv[i].e_r0 ? tv[i].c0 : tv[i].e_r1 ? tv[i].c1 : 3'd0));
            @(posedge clk); #1;
            chk($sformatf("v%0d rsp0_valid", i), 32'(rsp0_valid), 32'(tv[i].e_r0));
            chk($sformatf("v%0d rsp1_valid", i), 32'(rsp1_valid), 32'(tv[i].e_r1));
            if (tv[i].e_r0) begin
                chk($sformatf("v%0d rsp0_result", i), rsp0_result, tv[i].e_res);
                chk($sformatf("v%0d rsp0_eq", i), 32'(rsp0_eq), 32'(tv[i].e_eq));
            end
            if (tv[i].e_r1) begin
                chk($sformatf("v%0d rsp1_result", i), rsp1_result, tv[i].e_res);
                chk($sformatf("v%0d rsp1_eq", i), 32'(rsp1_eq), 32'(tv[i].e_eq));
            end
        end

        // Stalled slot 0: fill it, then hold rsp0_ready low while both request
        drive(1'b1, 32'd4, 32'd4, 3'd0, 1'b0, 32'd0, 32'd0, 3'd0);
        @(posedge clk); #1;
        chk("fill rsp0_result", rsp0_result, 32'd8);
        rsp0_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            drive(1'b1, 32'd9, 32'd1, 3'd1, 1'b1, 32'(k), 32'd1, 3'd0);
            #1;
            chk($sformatf("stall%0d req0_ready", k), 32'(req0_ready), 32'd0);
            chk($sformatf("stall%0d req1_ready", k), 32'(req1_ready), 32'd1);
            @(posedge clk); #1;
            chk($sformatf("stall%0d rsp0_result", k), rsp0_result, 32'd8);
            chk($sformatf("stall%0d rsp0_valid", k), 32'(rsp0_valid), 32'd1);
            chk($sformatf("stall%0d rsp1_result", k), rsp1_result, 32'(k + 1));
        end
        // Consume with nothing new: valid clears, data holds
        rsp0_ready = 1'b1;
        drive(1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 32'd0, 32'd0, 3'd0);
        @(posedge clk); #1;
        chk("drain rsp0_valid", 32'(rsp0_valid), 32'd0);
        chk("drain rsp0_result", rsp0_result, 32'd8);
        // Back-to-back consume and reload keeps slot 0 valid every cycle
        for (int k = 1; k <= 2; k++) begin
            drive(1'b1, 32'd100, 32'(k), 3'd0, 1'b0, 32'd0, 32'd0, 3'd0);
            #1;
            chk($sformatf("b2b%0d req0_ready", k), 32'(req0_ready), 32'd1);
            @(posedge clk); #1;
            chk($sformatf("b2b%0d rsp0_valid", k), 32'(rsp0_valid), 32'd1);
            chk($sformatf("b2b%0d rsp0_result", k), rsp0_result, 32'(100 + k));
        end

        // Asynchronous reset mid-cycle with a held response (pointer currently PRI1)
        rst_n = 1'b0;
        #1;
        chk("arst rsp0_valid", 32'(rsp0_valid), 32'd0);
        chk("arst rsp0_result", rsp0_result, 32'd0);
        chk("arst req0_ready", 32'(req0_ready), 32'd0);
        drive(1'b1, 32'd5, 32'd3, 3'd1, 1'b1, 32'd7, 32'd7, 3'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("rr%0d req0_ready", k), 32'(req0_ready), 32'(k % 2 == 0));
            chk($sformatf("rr%0d req1_ready", k), 32'(req1_ready), 32'(k % 2 == 1));
            @(posedge clk); #1;
            if (k % 2 == 0) chk($sformatf("rr%0d rsp0_result", k), rsp0_result, 32'd2);
            else begin
                chk($sformatf("rr%0d rsp1_result", k), rsp1_result, 32'd14);
                chk($sformatf("rr%0d rsp1_eq", k), 32'(rsp1_eq), 32'd1);
            end
        end

`ifdef ALU_ARB_STATS_EN
        rst_n = 1'b0;
        #1;
        chk("cnt rst gnt_cnt0", 32'(gnt_cnt0), 32'd0);
        drive(1'b1, 32'd1, 32'd1, 3'd0, 1'b0, 32'd0, 32'd0, 3'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
        end
        drive(1'b0, 32'd0, 32'd0, 3'd0, 1'b1, 32'd2, 32'd2, 3'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
        end
        drive(1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 32'd0, 32'd0, 3'd0);
        @(posedge clk); #1;
        chk("gnt_cnt0", 32'(gnt_cnt0), 32'd5);
        chk("gnt_cnt1", 32'(gnt_cnt1), 32'd3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
